// File: rtl/gpio_pkg.sv
// Shared constants and register decode for the GPIO input port (bus width, register offsets).
package gpio_pkg;

    localparam int unsigned GPIO_BUS_DW = 64;

    localparam logic [63:0] GPIO_LEVEL_OFS = 64'h00;
    localparam logic [63:0] GPIO_RISE_OFS  = 64'h08;
    localparam logic [63:0] GPIO_FALL_OFS  = 64'h10;

    typedef enum logic [1:0] {
        RegNone,
        RegLevel,
        RegRise,
        RegFall
    } gpio_reg_e;

    // Only an exact match on a mapped offset is a hit; everything else is ignored.
    function automatic gpio_reg_e gpio_decode(input logic        rd,
                                              input logic [63:0] addr,
                                              input logic [63:0] base);
        gpio_reg_e sel;
        sel = RegNone;
        if (rd) begin
            if (addr == base + GPIO_LEVEL_OFS) begin
                sel = RegLevel;
            end else if (addr == base + GPIO_RISE_OFS) begin
                sel = RegRise;
            end else if (addr == base + GPIO_FALL_OFS) begin
                sel = RegFall;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/gpio_sync_debounce.sv
// Per-pin 2-flop synchronizer plus optional tick-sampled debounce.
// Define GPIO_INPUT_DEBOUNCE_EN to build the prescaler and 3-sample debounce; otherwise
// the level is the synchronized pin.
module gpio_sync_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_level
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_gpio;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_INPUT_DEBOUNCE_EN
    localparam int unsigned PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DEBOUNCE_CYCLES - 1);

    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [WIDTH-1:0] r_hist0;
    logic [WIDTH-1:0] r_hist1;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_stable;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Current sample plus the two previous tick samples must all agree.
    assign w_stable = ~(r_sync2 ^ r_hist0) & ~(r_sync2 ^ r_hist1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_level <= '0;
        end else if (w_tick) begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_level <= (r_level & ~w_stable) | (r_sync2 & w_stable);
        end
    end

    assign o_level = r_level;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (DEBOUNCE_CYCLES >= 2);
    assign o_level      = r_sync2;
`endif

endmodule

// File: rtl/gpio_input_port.sv
// GPIO input port: edge capture and read-only/read-clear register access on the 64-bit bus.
// Debounce is enabled by defining GPIO_INPUT_DEBOUNCE_EN (see gpio_sync_debounce).
module gpio_input_port
    import gpio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0000_F100,
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       gpio_in,
    input  logic [63:0]            address,
    input  logic                   read,
    output logic [GPIO_BUS_DW-1:0] data_out,
    output logic                   drive_en
);

    logic [WIDTH-1:0]       w_level;
    logic [WIDTH-1:0]       r_level_prev;
    logic [WIDTH-1:0]       r_rise;
    logic [WIDTH-1:0]       r_fall;
    logic [WIDTH-1:0]       w_rise_evt;
    logic [WIDTH-1:0]       w_fall_evt;
    gpio_reg_e              w_sel;
    logic [GPIO_BUS_DW-1:0] w_rd_data;
    logic [GPIO_BUS_DW-1:0] r_data_out;
    logic                   r_drive_en;

    gpio_sync_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .i_gpio  (gpio_in),
        .o_level (w_level)
    );

    assign w_rise_evt = w_level & ~r_level_prev;
    assign w_fall_evt = ~w_level & r_level_prev;
    assign w_sel      = gpio_decode(read, address, BASE_ADDR);

    always_comb begin
        w_rd_data = '0;
        unique case (w_sel)
            RegLevel: w_rd_data[WIDTH-1:0] = w_level;
            RegRise:  w_rd_data[WIDTH-1:0] = r_rise;
            RegFall:  w_rd_data[WIDTH-1:0] = r_fall;
            default:  w_rd_data = '0;
        endcase
    end

    // Clear-on-read applies to the pre-edge value; a same-cycle edge ORs back in (set wins).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level_prev <= '0;
            r_rise       <= '0;
            r_fall       <= '0;
        end else begin
            r_level_prev <= w_level;
            r_rise       <= ((w_sel == RegRise) ? '0 : r_rise) | w_rise_evt;
            r_fall       <= ((w_sel == RegFall) ? '0 : r_fall) | w_fall_evt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_drive_en <= 1'b0;
        end else begin
            r_data_out <= w_rd_data;
            r_drive_en <= (w_sel != RegNone);
        end
    end

    assign data_out = r_data_out;
    assign drive_en = r_drive_en;

endmodule

// File: tb/tb_gpio_input_port.sv
// Randomized bench for gpio_input_port against a behavioural model of pins, ticks and registers.
module tb_gpio_input_port;

    localparam int unsigned W    = 32;
    localparam int unsigned D    = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_0000_F100;

    localparam logic [63:0] A_LEVEL = BASE + 64'h00;
    localparam logic [63:0] A_RISE  = BASE + 64'h08;
    localparam logic [63:0] A_FALL  = BASE + 64'h10;
    localparam logic [63:0] A_BAD   = BASE + 64'h18;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [W-1:0]  gpio_in;
    logic [63:0]   address;
    logic          read;
    logic [63:0]   data_out;
    logic          drive_en;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gpio_input_port #(
        .BASE_ADDR       (BASE),
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .gpio_in  (gpio_in),
        .address  (address),
        .read     (read),
        .data_out (data_out),
        .drive_en (drive_en)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_pins[$];     // m_pins[k] = pin value applied k+1 edges ago
    logic [W-1:0] m_samples[$];  // pin values seen at debounce ticks, most recent last
    logic [W-1:0] m_deb;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic [63:0]  m_resp_d;
    logic         m_resp_v;
    int           m_edges;

    task automatic model_reset();
        m_pins.delete();
        m_pins.push_back('0);
        m_pins.push_back('0);
        m_samples.delete();
        m_deb    = '0;
        m_prev   = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_resp_d = '0;
        m_resp_v = 1'b0;
        m_edges  = 0;
    endtask

    function automatic int decode(input logic rd, input logic [63:0] addr);
        if (!rd) return 0;
        if (addr == A_LEVEL) return 1;
        if (addr == A_RISE) return 2;
        if (addr == A_FALL) return 3;
        return 0;
    endfunction

    function automatic logic [W-1:0] model_level();
`ifdef GPIO_INPUT_DEBOUNCE_EN
        return m_deb;
`else
        return m_pins[1];
`endif
    endfunction

    task automatic model_edge();
        logic [W-1:0] lvl;
        int           sel;
        lvl      = model_level();
        sel      = decode(read, address);
        m_resp_v = (sel != 0);
        case (sel)
            1:       m_resp_d = 64'(lvl);
            2:       m_resp_d = 64'(m_rise);
            3:       m_resp_d = 64'(m_fall);
            default: m_resp_d = '0;
        endcase
        if (sel == 2) m_rise = '0;
        if (sel == 3) m_fall = '0;
        m_rise = m_rise | (lvl & ~m_prev);
        m_fall = m_fall | (~lvl & m_prev);
        m_prev = lvl;
`ifdef GPIO_INPUT_DEBOUNCE_EN
        if ((m_edges % D) == (D - 1)) begin
            int n;
            m_samples.push_back(m_pins[1]);
            n = m_samples.size();
            if (n >= 3) begin
                for (int b = 0; b < W; b++) begin
                    if (m_samples[n-1][b] == m_samples[n-2][b] &&
                        m_samples[n-2][b] == m_samples[n-3][b])
                        m_deb[b] = m_samples[n-1][b];
                end
            end
            if (m_samples.size() > 3) void'(m_samples.pop_front());
        end
`endif
        m_edges++;
        m_pins.push_front(gpio_in);
        void'(m_pins.pop_back());
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the next negedge with outputs checked against the model.
    task automatic cycle(input logic [W-1:0] pin, input logic rd, input logic [63:0] addr);
        gpio_in = pin;
        read    = rd;
        address = addr;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_eq("drive_en", 64'(drive_en), 64'(m_resp_v));
        check_eq("data_out", data_out, m_resp_d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        read    = 1'b0;
        address = '0;
        model_reset();
        #1;
        check_eq("rst_drive_en", 64'(drive_en), 64'h0);
        check_eq("rst_data_out", data_out, 64'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] pin;
        logic [63:0]  addr;
        logic         rd;
        bit           found;
        int           hold;

        reset_n = 1'b0;
        gpio_in = '0;
        read    = 1'b0;
        address = '0;
        model_reset();
        do_reset();

`ifdef GPIO_INPUT_DEBOUNCE_EN
        // Steady rise on bit0 must be debounced within 2+3*D cycles.
        found = 1'b0;
        for (int i = 0; i < 2 + 3 * D + 1 && !found; i++) begin
            cycle(32'h1, 1'b1, A_LEVEL);
            if (data_out == 64'h1) found = 1'b1;
        end
        check_eq("deb_level_in_time", 64'(found), 64'h1);
        cycle(32'h1, 1'b1, A_RISE);
        check_eq("deb_rise_first", data_out, 64'h1);
        cycle(32'h1, 1'b1, A_RISE);
        check_eq("deb_rise_cleared", data_out, 64'h0);
        // 5-cycle glitch on bit3 spans at most two ticks.
        repeat (5) cycle(32'h9, 1'b0, A_LEVEL);
        repeat (20) cycle(32'h1, 1'b0, A_LEVEL);
        cycle(32'h1, 1'b1, A_LEVEL);
        check_eq("glitch_level", data_out, 64'h1);
        cycle(32'h1, 1'b1, A_RISE);
        check_eq("glitch_rise", data_out, 64'h0);
`else
        cycle(32'hA5A5_A5A5, 1'b0, A_LEVEL);
        cycle(32'hA5A5_A5A5, 1'b0, A_LEVEL);
        cycle(32'hA5A5_A5A5, 1'b1, A_LEVEL);
        check_eq("level_a5", data_out, 64'h0000_0000_A5A5_A5A5);
        check_eq("level_a5_drive", 64'(drive_en), 64'h1);
        cycle(32'hA5A5_A5A5, 1'b1, A_RISE);
        check_eq("rise_a5", data_out, 64'h0000_0000_A5A5_A5A5);
        cycle(32'hA5A5_A5A5, 1'b1, A_RISE);
        check_eq("rise_a5_cleared", data_out, 64'h0);
        repeat (3) cycle(32'h0, 1'b0, A_LEVEL);
        cycle(32'h0, 1'b1, A_FALL);
        check_eq("fall_a5", data_out, 64'h0000_0000_A5A5_A5A5);
        // New bit2 edge captured in the same cycle as the RISE read.
        cycle(32'h4, 1'b0, A_LEVEL);
        cycle(32'h4, 1'b0, A_LEVEL);
        cycle(32'h4, 1'b1, A_RISE);
        check_eq("rise_same_cycle", data_out, 64'h0);
        check_eq("rise_same_cycle_drive", 64'(drive_en), 64'h1);
        cycle(32'h4, 1'b1, A_RISE);
        check_eq("rise_after_same_cycle", data_out, 64'h4);
`endif

        // Unmapped address and idle bus never drive.
        cycle(gpio_in, 1'b1, A_BAD);
        check_eq("bad_addr_drive", 64'(drive_en), 64'h0);
        check_eq("bad_addr_data", data_out, 64'h0);
        cycle(gpio_in, 1'b0, A_LEVEL);
        check_eq("no_read_drive", 64'(drive_en), 64'h0);

        // Reset asserted during a hit cycle aborts the response.
        gpio_in = 32'h3;
        read    = 1'b1;
        address = A_RISE;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_drive", 64'(drive_en), 64'h0);
        @(posedge clock);
        @(negedge clock);
        check_eq("mid_rst_no_resp", 64'(drive_en), 64'h0);
        check_eq("mid_rst_data", data_out, 64'h0);
        gpio_in = '0;
        read    = 1'b0;
        reset_n = 1'b1;
        cycle(32'h0, 1'b0, A_LEVEL);
        check_eq("post_rst_no_drive", 64'(drive_en), 64'h0);
        cycle(32'h0, 1'b1, A_RISE);
        check_eq("post_rst_rise", data_out, 64'h0);
        cycle(32'h0, 1'b1, A_FALL);
        check_eq("post_rst_fall", data_out, 64'h0);

        // Randomized traffic against the model.
        pin  = '0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) pin = W'($urandom());
                else pin = pin ^ (W'(1) << $urandom_range(0, W - 1));
                hold = $urandom_range(1, 24);
            end
            hold--;
            case ($urandom_range(0, 5))
                0:       addr = A_LEVEL;
                1:       addr = A_RISE;
                2:       addr = A_FALL;
                3:       addr = A_BAD;
                4:       addr = {$urandom(), $urandom()};
                default: addr = A_RISE;
            endcase
            rd = ($urandom_range(0, 2) != 0);
            cycle(pin, rd, addr);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_input_port.md
GPIO_INPUT_PORT -- requirements
Module: gpio_input_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_0000_F100, bus base address of the port.
REQ-002 SHALL have parameter WIDTH, default 32, number of input pins (1..32).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000, clock cycles per debounce sample tick (1 ms at 50 MHz; minimum 2).
REQ-004 clock  input  1  system clock (CLOCK_50 domain); all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 gpio_in  input  WIDTH  raw, asynchronous extension-board pins (GPIO1_D).
REQ-007 address  input  64  processor bus address.
REQ-008 read  input  1  processor bus read strobe, one cycle per access.
REQ-009 data_out  output  64  read data toward the shared processor data bus.
REQ-010 drive_en  output  1  high when data_out owns the shared data bus.

Function
REQ-011 SHALL pass each gpio_in bit through a 2-flop synchronizer; sync latency 2 cycles.
REQ-012 SHALL keep a prescaler counting 0..DEBOUNCE_CYCLES-1 and emit a one-cycle tick at wrap.
REQ-013 SHALL update a debounced level bit only when the synchronized bit has held the same value on 3 consecutive ticks.
REQ-014 SHALL set a sticky rise bit on a debounced 0->1 transition and a sticky fall bit on a debounced 1->0 transition.
REQ-015 Register map (offset from BASE_ADDR): 0x00 LEVEL (RO), 0x08 RISE (read-clear), 0x10 FALL (read-clear); data zero-extended to 64 bits.
REQ-016 A read hit is read=1 with address equal to BASE_ADDR+offset for a mapped offset; other addresses SHALL be ignored.
REQ-017 On a read hit in cycle N, data_out SHALL hold the register value sampled in cycle N and drive_en SHALL be 1 during cycle N+1 only.
REQ-018 Outside cycle N+1 of a hit, drive_en SHALL be 0 and data_out SHALL be 0.
REQ-019 A RISE/FALL read hit SHALL clear the read register at the end of cycle N.
REQ-020 An edge detected in the same cycle as its clearing read SHALL leave that bit set (set wins); the returned data excludes that new edge.
REQ-021 Back-to-back read hits on consecutive cycles SHALL each be served with one-cycle latency.
REQ-022 Bits above WIDTH SHALL read as 0.

Reset
REQ-023 While reset_n=0: synchronizers, history, LEVEL, RISE, FALL, prescaler, data_out all 0; drive_en 0.
REQ-024 Reset asserted mid-access SHALL abort the pending response; no drive_en pulse after release.
REQ-025 After release, initial LEVEL SHALL be 0 and an input already high SHALL produce a RISE edge once debounced.

Configuration
REQ-026 Macro GPIO_INPUT_DEBOUNCE_EN defined: REQ-012/013 debounce as specified.
REQ-027 Macro undefined: prescaler and history omitted; LEVEL SHALL equal the synchronized input each cycle (edge latency 3 cycles from pin).

Structure
REQ-028 Package gpio_pkg SHALL hold offset constants GPIO_LEVEL_OFS, GPIO_RISE_OFS, GPIO_FALL_OFS and the shared bus data width (64).
REQ-029 Sub-module gpio_sync_debounce SHALL contain synchronizer, prescaler and debounce per bit; gpio_input_port holds edge capture and bus decode.

Verification
REQ-030 DEBOUNCE_CYCLES=4, gpio_in[0] 0->1 steady -> LEVEL bit0=1 within 2+3*4 cycles; RISE=0x1; read 0x08 returns 0x1, next read 0x0.
REQ-031 gpio_in[3] glitches high for 5 cycles (DEBOUNCE_CYCLES=4) -> LEVEL and RISE unchanged (0).
REQ-032 Read RISE in the same cycle a new edge on bit2 is captured -> returned data lacks bit2; following read returns 0x4.
REQ-033 Read at BASE_ADDR+0x18 or read=0 -> drive_en stays 0, data_out 0.
REQ-034 Macro undefined, gpio_in=0xA5A5_A5A5 -> LEVEL read returns 64'h0000_0000_A5A5_A5A5 three cycles later.
REQ-035 reset_n pulsed low in cycle N of a hit -> no drive_en in N+1; RISE/FALL read 0 after release.
